// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480 timing, DAC colour values and pattern encoding.
// Used by the pattern generator and the bouncing-box mover.
package vga_pkg;

   localparam int H_ACTIVE_AREA = 640;
   localparam int H_FRONT_PORCH = 16;
   localparam int H_SYNC_PULSE  = 96;
   localparam int H_BACK_PORCH  = 48;
   localparam int H_TOTAL       = 800;
   localparam int V_ACTIVE_AREA = 480;
   localparam int V_FRONT_PORCH = 10;
   localparam int V_SYNC_PULSE  = 2;
   localparam int V_BACK_PORCH  = 33;
   localparam int V_TOTAL       = 525;

   localparam int BOX_SIZE = 32;
   localparam int BOX_STEP = 2;
   localparam int BAR_W    = H_ACTIVE_AREA / 8;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } rgb_t;

   localparam rgb_t C_BLACK = '{r: 3'd0, g: 3'd0, b: 3'd0};
   localparam rgb_t C_WHITE = '{r: 3'd7, g: 3'd7, b: 3'd7};
   localparam rgb_t C_RED   = '{r: 3'd7, g: 3'd0, b: 3'd0};
   localparam rgb_t C_GREEN = '{r: 3'd0, g: 3'd7, b: 3'd0};
   localparam rgb_t C_BKGND = '{r: 3'd0, g: 3'd0, b: 3'd3};

   typedef enum logic [1:0] {
      PAT_BARS    = 2'd0,
      PAT_CHECKER = 2'd1,
      PAT_BOX     = 2'd2,
      PAT_GRID    = 2'd3
   } pattern_e;

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: advances both axes by BOX_STEP on each frame tick and
// reverses direction (holding position for that tick) at the screen edges.
module vga_box_mover
   import vga_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_frame_tick,
   output logic [9:0] o_bx,
   output logic [9:0] o_by
);

   logic [9:0] bx;
   logic [9:0] by;
   logic       dx_neg;
   logic       dy_neg;

   // Edge tests are done at 11 bits so bx+BOX_SIZE+BOX_STEP cannot wrap.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         bx     <= '0;
         by     <= '0;
         dx_neg <= 1'b0;
         dy_neg <= 1'b0;
      end else if (i_frame_tick) begin
         if (!dx_neg) begin
            if (({1'b0, bx} + 11'(BOX_SIZE + BOX_STEP)) > 11'(H_ACTIVE_AREA))
               dx_neg <= 1'b1;
            else
               bx <= bx + 10'(BOX_STEP);
         end else begin
            if (bx < 10'(BOX_STEP))
               dx_neg <= 1'b0;
            else
               bx <= bx - 10'(BOX_STEP);
         end

         if (!dy_neg) begin
            if (({1'b0, by} + 11'(BOX_SIZE + BOX_STEP)) > 11'(V_ACTIVE_AREA))
               dy_neg <= 1'b1;
            else
               by <= by + 10'(BOX_STEP);
         end else begin
            if (by < 10'(BOX_STEP))
               dy_neg <= 1'b0;
            else
               by <= by - 10'(BOX_STEP);
         end
      end
   end

   assign o_bx = bx;
   assign o_by = by;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage behind the VGA sync generator: two-stage pipeline
// that keeps colour and sync aligned, with per-frame pattern select and box motion.
module vga_pattern_gen
   import vga_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_hs,
   input  logic       i_vs,
   input  logic       i_activeArea,
   input  logic [9:0] i_px,
   input  logic [9:0] i_py,
   input  logic       i_nextPattern,
   output logic       o_hs,
   output logic       o_vs,
   output logic [2:0] o_red,
   output logic [2:0] o_grn,
   output logic [2:0] o_blu,
   output logic [1:0] o_pattern
);

   logic       vs_prev;
   logic       frame_tick;
   logic       pending;
   pattern_e   pattern;
   logic [9:0] bx;
   logic [9:0] by;

   // Frame tick on the falling edge of vsync, i.e. inside vertical blanking.
   assign frame_tick = vs_prev & ~i_vs;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         vs_prev <= 1'b0;
         pending <= 1'b0;
         pattern <= PAT_BARS;
      end else begin
         vs_prev <= i_vs;
         if (frame_tick) begin
            if (pending || i_nextPattern)
               pattern <= pattern_e'(pattern + 2'd1);
            pending <= 1'b0;
         end else if (i_nextPattern) begin
            pending <= 1'b1;
         end
      end
   end

   vga_box_mover u_box (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_frame_tick (frame_tick),
      .o_bx         (bx),
      .o_by         (by)
   );

   // Stage 1: register sync, active flag and coordinates.
   logic       hs_p1;
   logic       vs_p1;
   logic       vld_p1;
   logic [9:0] px_p1;
   logic [9:0] py_p1;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
         vld_p1 <= 1'b0;
      end else begin
         hs_p1  <= i_hs;
         vs_p1  <= i_vs;
         vld_p1 <= i_activeArea;
      end
   end

   always_ff @(posedge i_clk) begin
      px_p1 <= i_px;
      py_p1 <= i_py;
   end

   logic [2:0] bar_idx;
   logic       in_box;
   rgb_t       pix;

   always_comb begin
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++)
         if (px_p1 >= 10'(k * BAR_W))
            bar_idx = bar_idx + 3'd1;

      in_box = ({1'b0, px_p1} >= {1'b0, bx}) &&
               ({1'b0, px_p1} <  ({1'b0, bx} + 11'(BOX_SIZE))) &&
               ({1'b0, py_p1} >= {1'b0, by}) &&
               ({1'b0, py_p1} <  ({1'b0, by} + 11'(BOX_SIZE)));

      pix = C_BLACK;
      case (pattern)
         PAT_BARS: begin
            pix.r = bar_idx[2] ? 3'd7 : 3'd0;
            pix.g = bar_idx[1] ? 3'd7 : 3'd0;
            pix.b = bar_idx[0] ? 3'd7 : 3'd0;
         end
         PAT_CHECKER: pix = (px_p1[5] ^ py_p1[5]) ? C_WHITE : C_BLACK;
         PAT_BOX:     pix = in_box ? C_RED : C_BKGND;
         PAT_GRID: begin
            if (px_p1 == 10'd0 || px_p1 == 10'(H_ACTIVE_AREA - 1) ||
                py_p1 == 10'd0 || py_p1 == 10'(V_ACTIVE_AREA - 1))
               pix = C_WHITE;
            else if (px_p1[4:0] == 5'd0 || py_p1[4:0] == 5'd0)
               pix = C_GREEN;
            else
               pix = C_BLACK;
         end
         default: pix = C_BLACK;
      endcase
   end

   // Stage 2: register colour alongside the stage-1 sync.
   logic hs_p2;
   logic vs_p2;
   rgb_t rgb_p2;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         hs_p2  <= 1'b1;
         vs_p2  <= 1'b1;
         rgb_p2 <= C_BLACK;
      end else begin
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
         rgb_p2 <= vld_p1 ? pix : C_BLACK;
      end
   end

   assign o_hs      = hs_p2;
   assign o_vs      = vs_p2;
   assign o_red     = rgb_p2.r;
   assign o_grn     = rgb_p2.g;
   assign o_blu     = rgb_p2.b;
   assign o_pattern = pattern;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: the driver pushes expected sync/colour
// from a frame-level reference model, the monitor pops and compares each cycle.
module tb_vga_pattern_gen;

   localparam int H_ACT = 640;
   localparam int V_ACT = 480;
   localparam int BOX   = 32;
   localparam int STEP  = 2;

   logic       clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       i_hs = 1'b1;
   logic       i_vs = 1'b1;
   logic       i_activeArea = 1'b0;
   logic [9:0] i_px = '0;
   logic [9:0] i_py = '0;
   logic       i_nextPattern = 1'b0;
   logic       o_hs;
   logic       o_vs;
   logic [2:0] o_red;
   logic [2:0] o_grn;
   logic [2:0] o_blu;
   logic [1:0] o_pattern;

   always #5 clk = ~clk;

   vga_pattern_gen dut (
      .i_clk         (clk),
      .i_reset_n     (i_reset_n),
      .i_hs          (i_hs),
      .i_vs          (i_vs),
      .i_activeArea  (i_activeArea),
      .i_px          (i_px),
      .i_py          (i_py),
      .i_nextPattern (i_nextPattern),
      .o_hs          (o_hs),
      .o_vs          (o_vs),
      .o_red         (o_red),
      .o_grn         (o_grn),
      .o_blu         (o_blu),
      .o_pattern     (o_pattern)
   );

   typedef struct {
      logic       hs;
      logic       vs;
      logic [8:0] rgb;
      logic [1:0] pat;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state: pattern, pending request, frame ticks since reset.
   int   m_pat = 0;
   int   m_pend = 0;
   int   m_ticks = 0;
   logic m_vsprev = 1'b0;

   // Box position as a triangle wave of the tick count: climbs by STEP for n
   // ticks, holds one tick at the far edge, descends n ticks, holds one at 0.
   function automatic int box_pos(input int t, input int span);
      int n, m;
      n = (span - BOX) / STEP;
      m = t % (2 * (n + 1));
      return (m <= n) ? STEP * m : STEP * (2 * n + 1 - m);
   endfunction

   function automatic logic [8:0] ref_colour(input int pat, input int px, input int py,
                                             input int bx, input int by);
      int idx;
      case (pat)
         0: begin
            idx = px / (H_ACT / 8);
            if (idx > 7) idx = 7;
            return {((idx & 4) != 0) ? 3'd7 : 3'd0,
                    ((idx & 2) != 0) ? 3'd7 : 3'd0,
                    ((idx & 1) != 0) ? 3'd7 : 3'd0};
         end
         1: return ((((px / 32) + (py / 32)) % 2) == 1) ? 9'o777 : 9'o000;
         2: return (px >= bx && px < bx + BOX && py >= by && py < by + BOX) ? 9'o700 : 9'o003;
         default: begin
            if (px == 0 || px == H_ACT - 1 || py == 0 || py == V_ACT - 1) return 9'o777;
            if (px % 32 == 0 || py % 32 == 0) return 9'o070;
            return 9'o000;
         end
      endcase
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // One input cycle: apply inputs, advance the model, push the expectation.
   task automatic drive(input logic rn, input logic hs, input logic vs, input logic act,
                        input int px, input int py, input logic np);
      exp_t e;
      exp_t prev;
      int   idx;
      i_reset_n     = rn;
      i_hs          = hs;
      i_vs          = vs;
      i_activeArea  = act;
      i_px          = 10'(px);
      i_py          = 10'(py);
      i_nextPattern = np;
      if (!rn) begin
         m_pat = 0; m_pend = 0; m_ticks = 0; m_vsprev = 1'b0;
         e.hs = 1'b1; e.vs = 1'b1; e.rgb = '0; e.pat = 2'd0;
         // Reset also flushes the stage-1 contents of the previous cycle.
         if (q.size() > 0) begin
            idx = q.size() - 1;
            prev = q[idx];
            prev.hs = 1'b1; prev.vs = 1'b1; prev.rgb = '0;
            q[idx] = prev;
         end
      end else begin
         if (m_vsprev && !vs) begin
            m_ticks++;
            if (m_pend != 0 || np) m_pat = (m_pat + 1) % 4;
            m_pend = 0;
         end else if (np) begin
            m_pend = 1;
         end
         m_vsprev = vs;
         e.hs  = hs;
         e.vs  = vs;
         e.rgb = act ? ref_colour(m_pat, px, py, box_pos(m_ticks, H_ACT), box_pos(m_ticks, V_ACT))
                     : 9'o000;
         e.pat = 2'(m_pat);
      end
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic np);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, np);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic goto_pattern(input int p);
      for (int i = 0; i < 8; i++) begin
         if (m_pat == p) break;
         tick(1'b1);
      end
   endtask

   task automatic pix(input int px, input int py);
      drive(1'b1, 1'b1, 1'b1, 1'b1, px, py, 1'b0);
   endtask

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Monitor: output of the cycle-k inputs is visible once cycles k+1, k+2 were driven.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() >= 3) begin
            e = q.pop_front();
            check("o_hs", int'(o_hs), int'(e.hs));
            check("o_vs", int'(o_vs), int'(e.vs));
            check("rgb", int'({o_red, o_grn, o_blu}), int'(e.rgb));
            check("o_pattern", int'(o_pattern), int'(q[0].pat));
         end
      end
   end

   initial begin
      int bx, by;
      int ox[6] = '{-1, 0, 31, 32, 5, 5};
      int oy[6] = '{1, 0, 31, 16, -1, 32};

      // Reset with sync toggling: outputs must stay at their reset values.
      for (int i = 0; i < 4; i++)
         drive(1'b0, 1'(i % 2), 1'(i / 2), 1'b1, 80, 0, 1'b0);

      // Pattern 0 bars at the reference columns.
      pix(0, 0);
      pix(80, 0);
      pix(639, 0);
      pix(559, 10);
      pix(560, 10);

      // Arbitrary sync waveform with random pixels and occasional requests.
      for (int i = 0; i < 300; i++)
         drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, H_ACT - 1),
               $urandom_range(0, V_ACT - 1), 1'($urandom_range(0, 7) == 0));

      // Several requests in one frame advance once; a request on the tick counts.
      goto_pattern(0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
         drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      end
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
      tick(1'b0);

      // Random visible pixels in every pattern.
      for (int p = 0; p < 4; p++) begin
         goto_pattern(p);
         for (int i = 0; i < 120; i++)
            pix($urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
      end

      // Long run of frames in pattern 2, probing around the box edges.
      for (int f = 0; f < 650; f++) begin
         tick(1'(m_pat != 2));
         bx = box_pos(m_ticks, H_ACT);
         by = box_pos(m_ticks, V_ACT);
         for (int k = 0; k < 6; k++)
            pix(clampi(bx + ox[k], 0, H_ACT - 1), clampi(by + oy[k], 0, V_ACT - 1));
      end

      // Grid pattern corner cases.
      goto_pattern(3);
      pix(32, 5);
      pix(0, 100);
      pix(33, 33);
      pix(639, 200);
      pix(100, 479);
      pix(64, 70);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32, 5, 1'b0);

      // Reset in mid-frame with the box displaced and pattern 2 showing.
      goto_pattern(2);
      for (int i = 0; i < 50; i++) tick(1'b0);
      pix(box_pos(m_ticks, H_ACT), box_pos(m_ticks, V_ACT));
      pix(box_pos(m_ticks, H_ACT) + 1, box_pos(m_ticks, V_ACT) + 1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 200, 200, 1'b0);
      pix(0, 0);
      pix(80, 0);
      pix(320, 240);
      tick(1'b0);
      pix(0, 0);

      for (int i = 0; i < 3; i++)
         drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
